// File: rtl/add_sub_arbiter_pkg.sv
// Shared constants and round-robin helper for the add/sub arbiter.
package add_sub_arbiter_pkg;

   localparam int unsigned RR_IDX_W    = 4;
   localparam int unsigned RSP_FLAGS_W = 3;
   localparam int unsigned FLAG_CARRY  = 0;
   localparam int unsigned FLAG_OVF    = 1;
   localparam int unsigned FLAG_UNF    = 2;

   // Next requester index after idx, wrapping at n.
   function automatic logic [RR_IDX_W-1:0] rr_next(input logic [RR_IDX_W-1:0] idx,
                                                   input logic [RR_IDX_W:0]   n);
      logic [RR_IDX_W:0] nxt;
      nxt = {1'b0, idx} + (RR_IDX_W+1)'(1);
      return (nxt >= n) ? '0 : nxt[RR_IDX_W-1:0];
   endfunction

endpackage

// File: rtl/add_sub_arbiter_addsub.sv
// Combinational adder/subtractor with unsigned or two's-complement saturation.
module add_sub_arbiter_addsub #(
   parameter int unsigned DSIZE = 8
) (
   input  logic [DSIZE-1:0] a_i,
   input  logic [DSIZE-1:0] b_i,
   input  logic             sub_i,
   input  logic             tc_i,
   output logic [DSIZE-1:0] sum_o,
   output logic [DSIZE-1:0] clip_o,
   output logic             carry_o,
   output logic             ovf_o,
   output logic             unf_o
);

   logic [DSIZE-1:0] b_eff;
   logic [DSIZE:0]   raw;
   logic             s_ovf;

   // Subtraction as A + ~B + 1, so carry-out means "no borrow".
   assign b_eff   = sub_i ? ~b_i : b_i;
   assign raw     = {1'b0, a_i} + {1'b0, b_eff} + (DSIZE+1)'(sub_i);
   assign sum_o   = raw[DSIZE-1:0];
   assign carry_o = raw[DSIZE];
   assign s_ovf   = (a_i[DSIZE-1] == b_eff[DSIZE-1]) && (sum_o[DSIZE-1] != a_i[DSIZE-1]);

   always_comb begin
      ovf_o  = 1'b0;
      unf_o  = 1'b0;
      clip_o = sum_o;
      if (tc_i) begin
         ovf_o = s_ovf & ~a_i[DSIZE-1];
         unf_o = s_ovf &  a_i[DSIZE-1];
      end else begin
         ovf_o = ~sub_i & carry_o;
         unf_o =  sub_i & ~carry_o;
      end
      if (ovf_o) begin
         clip_o = tc_i ? {1'b0, {(DSIZE-1){1'b1}}} : '1;
      end else if (unf_o) begin
         clip_o = tc_i ? {1'b1, {(DSIZE-1){1'b0}}} : '0;
      end
   end

endmodule

// File: rtl/add_sub_arbiter.sv
// Round-robin sharing of one adder/subtractor between NREQ requesters,
// with a registered operand stage and a registered result stage.
module add_sub_arbiter
   import add_sub_arbiter_pkg::*;
#(
   parameter int unsigned DSIZE = 8,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDW   = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [NREQ-1:0]       req_valid_i,
   output logic [NREQ-1:0]       req_ready_o,
   input  logic [NREQ*DSIZE-1:0] req_a_i,
   input  logic [NREQ*DSIZE-1:0] req_b_i,
   input  logic [NREQ-1:0]       req_sub_i,
   input  logic [NREQ-1:0]       req_tc_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [IDW-1:0]        rsp_id_o,
   output logic [DSIZE-1:0]      rsp_sum_o,
   output logic [DSIZE-1:0]      rsp_clip_o,
   output logic                  rsp_carry_o,
   output logic                  rsp_ovf_o,
   output logic                  rsp_unf_o,
   output logic                  busy_o
);

   localparam int unsigned PAD_W = 1 << RR_IDX_W;

   logic [IDW-1:0]         last_q, last_d;
   logic                   v1_q, v1_d;
   logic [DSIZE-1:0]       a1_q, a1_d, b1_q, b1_d;
   logic                   sub1_q, sub1_d, tc1_q, tc1_d;
   logic [IDW-1:0]         id1_q, id1_d;
   logic                   v2_q, v2_d;
   logic [DSIZE-1:0]       sum2_q, sum2_d, clip2_q, clip2_d;
   logic [RSP_FLAGS_W-1:0] flags2_q, flags2_d;
   logic [IDW-1:0]         id2_q, id2_d;

   logic                   adv1, adv2, accept;
   logic [PAD_W-1:0]       valid_pad;
   logic [RR_IDX_W-1:0]    idx, gnt_idx;
   logic                   gnt_found;
   logic [DSIZE-1:0]       sel_a, sel_b;
   logic                   sel_sub, sel_tc;

   logic [DSIZE-1:0]       add_sum, add_clip;
   logic                   add_carry, add_ovf, add_unf;

   assign adv2   = ~v2_q | rsp_ready_i;
   assign adv1   = ~v1_q | adv2;
   assign accept = rst_n_i & adv1 & gnt_found;

   // Search requesters starting just after the last granted one.
   always_comb begin
      valid_pad = PAD_W'(req_valid_i);
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx       = rr_next(RR_IDX_W'(last_q), (RR_IDX_W+1)'(NREQ));
      for (int i = 0; i < NREQ; i++) begin
         if (!gnt_found && valid_pad[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = idx;
         end
         idx = rr_next(idx, (RR_IDX_W+1)'(NREQ));
      end
   end

   always_comb begin
      sel_a       = '0;
      sel_b       = '0;
      sel_sub     = 1'b0;
      sel_tc      = 1'b0;
      req_ready_o = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (RR_IDX_W'(k) == gnt_idx) begin
            sel_a   = req_a_i[k*DSIZE +: DSIZE];
            sel_b   = req_b_i[k*DSIZE +: DSIZE];
            sel_sub = req_sub_i[k];
            sel_tc  = req_tc_i[k];
         end
         req_ready_o[k] = accept && (RR_IDX_W'(k) == gnt_idx);
      end
   end

   add_sub_arbiter_addsub #(
      .DSIZE (DSIZE)
   ) u_addsub (
      .a_i     (a1_q),
      .b_i     (b1_q),
      .sub_i   (sub1_q),
      .tc_i    (tc1_q),
      .sum_o   (add_sum),
      .clip_o  (add_clip),
      .carry_o (add_carry),
      .ovf_o   (add_ovf),
      .unf_o   (add_unf)
   );

   // Stage advance: S2 drains the old S1 while S1 takes the new grant.
   always_comb begin
      last_d   = last_q;
      v1_d     = v1_q;
      a1_d     = a1_q;
      b1_d     = b1_q;
      sub1_d   = sub1_q;
      tc1_d    = tc1_q;
      id1_d    = id1_q;
      v2_d     = v2_q;
      sum2_d   = sum2_q;
      clip2_d  = clip2_q;
      flags2_d = flags2_q;
      id2_d    = id2_q;
      if (adv1) begin
         v1_d = accept;
         if (accept) begin
            a1_d   = sel_a;
            b1_d   = sel_b;
            sub1_d = sel_sub;
            tc1_d  = sel_tc;
            id1_d  = IDW'(gnt_idx);
            last_d = IDW'(gnt_idx);
         end
      end
      if (adv2) begin
         v2_d = v1_q;
         if (v1_q) begin
            sum2_d               = add_sum;
            clip2_d              = add_clip;
            flags2_d[FLAG_CARRY] = add_carry;
            flags2_d[FLAG_OVF]   = add_ovf;
            flags2_d[FLAG_UNF]   = add_unf;
            id2_d                = id1_q;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         last_q   <= IDW'(NREQ - 1);
         v1_q     <= 1'b0;
         a1_q     <= '0;
         b1_q     <= '0;
         sub1_q   <= 1'b0;
         tc1_q    <= 1'b0;
         id1_q    <= '0;
         v2_q     <= 1'b0;
         sum2_q   <= '0;
         clip2_q  <= '0;
         flags2_q <= '0;
         id2_q    <= '0;
      end else begin
         last_q   <= last_d;
         v1_q     <= v1_d;
         a1_q     <= a1_d;
         b1_q     <= b1_d;
         sub1_q   <= sub1_d;
         tc1_q    <= tc1_d;
         id1_q    <= id1_d;
         v2_q     <= v2_d;
         sum2_q   <= sum2_d;
         clip2_q  <= clip2_d;
         flags2_q <= flags2_d;
         id2_q    <= id2_d;
      end
   end

   assign rsp_valid_o = v2_q;
   assign rsp_id_o    = id2_q;
   assign rsp_sum_o   = sum2_q;
   assign rsp_clip_o  = clip2_q;
   assign rsp_carry_o = flags2_q[FLAG_CARRY];
   assign rsp_ovf_o   = flags2_q[FLAG_OVF];
   assign rsp_unf_o   = flags2_q[FLAG_UNF];
   assign busy_o      = v1_q | v2_q;

endmodule
